dmem_responder: RTL

- Multi-cycle data-memory responder; the memory-side end of the CPU load/store interface.
- Accepts one word read or write per request over a req/ack handshake and completes it a fixed, parameterized number of cycles later.
- Sits between the CPU datapath (address from the ALU result, write data from busB) and the word array.
- Replaces the zero-wait-state store for multi-cycle and timing experiments.

---
 rtl/dmem_responder.sv | 71 +++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word memory responder with req/ack handshake, fixed LATENCY, range (and optional DMEM_ALIGN_CHECK_EN misalignment) errors
//   CLK   - clock; Reset - async active-high reset
//   req/we/addr/wdata - request inputs, sampled when idle or acking
//   rdata/ack/busy/err - completion data, one-cycle ack pulse, outstanding flag, error flag valid with ack
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        accept, done, bad;
  logic [31:0] mem [DEPTH];
  // a new request may be taken in IDLE or in the ACK cycle (back-to-back)
  assign accept = req && state_q != WAIT;
  assign done   = state_q == WAIT && cnt_q == '0;
`ifdef DMEM_ALIGN_CHECK_EN
  assign bad = addr_q[31:AW+2] != '0 || addr_q[1:0] != '0;
`else
  assign bad = addr_q[31:AW+2] != '0;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_q[1:0];
`endif
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= done && bad;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (done && (bad || !we_q)) rdata_q <= bad ? '0 : mem[addr_q[AW+1:2]];
    end
  end
  always_ff @(posedge CLK)
    if (done && we_q && !bad) mem[addr_q[AW+1:2]] <= wdata_q;
  always_comb begin
    state_d = accept ? WAIT : done ? ACK : state_q == ACK ? IDLE : state_q;
    cnt_d   = accept ? 4'(LATENCY - 1) : (state_q == WAIT && cnt_q != '0) ? cnt_q - 4'd1 : cnt_q;
  end
  always_comb begin
    ack   = state_q == ACK;
    busy  = state_q != IDLE;
    err   = err_q;
    rdata = rdata_q;
  end
endmodule
